// File: rtl/morty_dmem_port.sv
// Purpose: MEM-stage load/store unit that drives a single-master Wishbone-style data bus and returns formatted load data.
// Latency: request in IDLE, bus cycle from the next edge, result in DONE; the minimum is 3 cycles with 2 of them stalled.
// Backpressure: mem_stall holds IF..MEM while a cycle is outstanding; every dmem_ack wait state adds one stalled cycle.
module morty_dmem_port (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_result,
   input  logic [31:0] mem_store_data,
   input  logic [5:0]  mem_mem_flags,
   input  logic        mem_trap_valid,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_dat_o,
   output logic [3:0]  dmem_sel,
   output logic        dmem_we,
   output logic        dmem_cyc,
   output logic        dmem_stb,
   input  logic [31:0] dmem_dat_i,
   input  logic        dmem_ack,
   input  logic        dmem_err,
   output logic [31:0] mem_load_data,
   output logic        mem_stall,
   output logic        mem_exc_valid,
   output logic [3:0]  mem_exc_code,
   output logic [31:0] mem_exc_addr
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic        cyc_q, cyc_d;
   logic [31:0] ea_q, ea_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] load_q, load_d;
   logic        err_q, err_d;
   logic [3:0]  code_q, code_d;
   logic [31:0] exc_addr_q, exc_addr_d;

   logic        rd, wr, req, misal;
   logic [1:0]  size;
   logic [3:0]  sel_c;
   logic [31:0] dat_c;
   logic [31:0] lane;
   logic [31:0] fmt;
   logic        unused_flag;

   assign rd          = mem_mem_flags[0];
   assign wr          = mem_mem_flags[1];
   assign size        = mem_mem_flags[3:2];
   assign unused_flag = mem_mem_flags[5];
   assign req         = (rd ^ wr) & ~mem_trap_valid;

   // Decode alignment and the store lane pattern from the live EX/MEM fields
   always_comb begin
      misal = 1'b0;
      sel_c = 4'b1111;
      dat_c = mem_store_data;
      case (size)
         2'b00: begin
            sel_c = 4'b0001 << mem_result[1:0];
            dat_c = {4{mem_store_data[7:0]}};
         end
         2'b01: begin
            misal = mem_result[0];
            sel_c = mem_result[1] ? 4'b1100 : 4'b0011;
            dat_c = {2{mem_store_data[15:0]}};
         end
         2'b10: misal = (mem_result[1:0] != 2'b00);
         default: misal = 1'b1;
      endcase
   end

   // Shift the addressed lane down and extend it according to the captured access size
   always_comb begin
      lane = dmem_dat_i >> {ea_q[1:0], 3'b000};
      fmt  = dmem_dat_i;
      case (size_q)
         2'b00:   fmt = {{24{~uns_q & lane[7]}}, lane[7:0]};
         2'b01:   fmt = {{16{~uns_q & lane[15]}}, lane[15:0]};
         default: fmt = dmem_dat_i;
      endcase
   end

   // Next-state logic: launch aligned requests, wait for ack/err (err wins), then one DONE cycle
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      dat_d      = dat_q;
      sel_d      = sel_q;
      we_d       = we_q;
      cyc_d      = cyc_q;
      ea_d       = ea_q;
      size_d     = size_q;
      uns_d      = uns_q;
      load_d     = load_q;
      err_d      = err_q;
      code_d     = code_q;
      exc_addr_d = exc_addr_q;
      case (state_q)
         IDLE: begin
            if (req && !misal) begin
               state_d = BUSY;
               addr_d  = mem_result[31:2];
               dat_d   = dat_c;
               sel_d   = sel_c;
               we_d    = wr;
               cyc_d   = 1'b1;
               ea_d    = mem_result;
               size_d  = size;
               uns_d   = mem_mem_flags[4];
            end
         end
         BUSY: begin
            if (dmem_err) begin
               state_d    = DONE;
               cyc_d      = 1'b0;
               we_d       = 1'b0;
               err_d      = 1'b1;
               code_d     = we_q ? 4'd7 : 4'd5;
               exc_addr_d = ea_q;
            end else if (dmem_ack) begin
               state_d = DONE;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               err_d   = 1'b0;
               if (!we_q) load_d = fmt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bus registers; async reset drops the bus cycle immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         ea_q       <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         load_q     <= '0;
         err_q      <= 1'b0;
         code_q     <= '0;
         exc_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         dat_q      <= dat_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         cyc_q      <= cyc_d;
         ea_q       <= ea_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         load_q     <= load_d;
         err_q      <= err_d;
         code_q     <= code_d;
         exc_addr_q <= exc_addr_d;
      end
   end

   // Pipeline-facing outputs: misalignment is reported combinationally in IDLE, bus errors from DONE
   always_comb begin
      mem_stall     = rst & (((state_q == IDLE) & req & ~misal) | (state_q == BUSY));
      mem_exc_valid = 1'b0;
      mem_exc_code  = code_q;
      mem_exc_addr  = exc_addr_q;
      if (state_q == IDLE && req && misal) begin
         mem_exc_valid = 1'b1;
         mem_exc_code  = wr ? 4'd6 : 4'd4;
         mem_exc_addr  = mem_result;
      end else if (state_q == DONE) begin
         mem_exc_valid = err_q;
      end
   end

   assign dmem_addr     = {addr_q, 2'b00};
   assign dmem_dat_o    = dat_q;
   assign dmem_sel      = sel_q;
   assign dmem_we       = we_q;
   assign dmem_cyc      = cyc_q;
   assign dmem_stb      = cyc_q;
   assign mem_load_data = load_q;

endmodule
